// File: rtl/coord_track_pkg.sv
// Shared types, coordinate-word field layout and the word packing helper
// for the coord_tracker blob locator.
package coord_track_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int VALID_BIT = 31;
  localparam int CNT_W     = 11;
  localparam int CNT_LSB   = 20;
  localparam int CY_LSB    = 10;
  localparam int CX_LSB    = 0;
  localparam int FIELD_W   = 10;

  // An empty class always packs to zero, whatever the centre arithmetic gave.
  function automatic logic [31:0] pack_coord(
    input logic               valid,
    input logic [CNT_W-1:0]   cnt,
    input logic [FIELD_W-1:0] cy,
    input logic [FIELD_W-1:0] cx
  );
    logic [31:0] word;
    word = 32'h0;
    if (cnt != {CNT_W{1'b0}}) begin
      word[VALID_BIT]            = valid;
      word[CNT_LSB +: CNT_W]     = cnt;
      word[CY_LSB +: FIELD_W]    = cy;
      word[CX_LSB +: FIELD_W]    = cx;
    end else begin
      word = 32'h0;
    end
    return word;
  endfunction

endpackage

// File: rtl/coord_class_stats.sv
// Per-class bounding box and saturating pixel count accumulator with a
// synchronous clear; clear takes priority over an update in the same cycle.
module coord_class_stats
  import coord_track_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_upd,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [COORD_W-1:0] o_min_x,
  output logic [COORD_W-1:0] o_max_x,
  output logic [COORD_W-1:0] o_min_y,
  output logic [COORD_W-1:0] o_max_y,
  output logic [CNT_W-1:0]   o_cnt
);

  logic [COORD_W-1:0] r_min_x;
  logic [COORD_W-1:0] r_max_x;
  logic [COORD_W-1:0] r_min_y;
  logic [COORD_W-1:0] r_max_y;
  logic [CNT_W-1:0]   r_cnt;

  // Bounding box and count update.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_min_x <= {COORD_W{1'b1}};
      r_max_x <= {COORD_W{1'b0}};
      r_min_y <= {COORD_W{1'b1}};
      r_max_y <= {COORD_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_upd) begin
      if (i_x < r_min_x) r_min_x <= i_x;
      if (i_x > r_max_x) r_max_x <= i_x;
      if (i_y < r_min_y) r_min_y <= i_y;
      if (i_y > r_max_y) r_max_y <= i_y;
      if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_min_x = r_min_x;
  assign o_max_x = r_max_x;
  assign o_min_y = r_min_y;
  assign o_max_y = r_max_y;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/coord_tracker.sv
// Per-frame colour-blob locator: accumulates per-class boxes and flushes one
// packed word per class at end of frame. Optional macro: COORD_TRACK_MIN_COUNT_EN.
module coord_tracker
  import coord_track_pkg::*;
#(
  parameter int NUM_CLASSES = 8,
  parameter int CLASS_W     = 5,
  parameter int COORD_W     = 10,
  parameter int MIN_PIXELS  = 16
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               sof,
  input  logic               eof,
  input  logic               pix_valid,
  input  logic [CLASS_W-1:0] pix_class,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [4:0]         coords_ram_write_addr,
  output logic               coords_ram_write_en,
  output logic [31:0]        coords_ram_write_data,
  output logic               frame_done,
  output logic               overrun
);

  state_t r_state;
  state_t w_next_state;
  logic [4:0]  r_idx;
  logic        r_sof_pend;
  logic        r_overrun;
  logic        r_wr_en;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_frame_done;
  logic        w_clear;
  logic        w_accum;
  logic        w_last;
  logic        w_late_sof;

  logic [COORD_W-1:0] w_min_x [NUM_CLASSES];
  logic [COORD_W-1:0] w_max_x [NUM_CLASSES];
  logic [COORD_W-1:0] w_min_y [NUM_CLASSES];
  logic [COORD_W-1:0] w_max_y [NUM_CLASSES];
  logic [CNT_W-1:0]   w_cnt   [NUM_CLASSES];

  logic [COORD_W-1:0] w_sel_min_x;
  logic [COORD_W-1:0] w_sel_max_x;
  logic [COORD_W-1:0] w_sel_min_y;
  logic [COORD_W-1:0] w_sel_max_y;
  logic [CNT_W-1:0]   w_sel_cnt;
  logic [COORD_W-1:0] w_cx;
  logic [COORD_W-1:0] w_cy;
  logic               w_valid;
  logic [31:0]        w_word;

  // Out-of-range classes simply match no accumulator and are dropped.
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
    coord_class_stats #(.COORD_W(COORD_W)) u_stats (
      .i_clk   (clk_clk),
      .i_rst   (reset_reset),
      .i_clear (w_clear),
      .i_upd   (w_accum && pix_valid && (pix_class == CLASS_W'(c))),
      .i_x     (pix_x),
      .i_y     (pix_y),
      .o_min_x (w_min_x[c]),
      .o_max_x (w_max_x[c]),
      .o_min_y (w_min_y[c]),
      .o_max_y (w_max_y[c]),
      .o_cnt   (w_cnt[c])
    );
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_accum      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (sof) w_next_state = ACCUM;
        else     w_next_state = IDLE;
      end
      ACCUM: begin
        w_accum = 1'b1;
        if (eof) begin
          w_next_state = FLUSH;
        end else if (sof) begin
          w_clear      = 1'b1;
          w_next_state = ACCUM;
        end else begin
          w_next_state = ACCUM;
        end
      end
      FLUSH: begin
        if (r_idx == 5'(NUM_CLASSES - 1)) begin
          w_last       = 1'b1;
          w_clear      = 1'b1;
          w_next_state = (r_sof_pend || sof) ? ACCUM : IDLE;
        end else begin
          w_next_state = FLUSH;
        end
      end
      default: begin
        w_clear      = 1'b1;
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_late_sof = sof && ((r_state == FLUSH) || ((r_state == ACCUM) && eof));

  // State, flush index, pending-sof latch and sticky overrun.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state    <= IDLE;
      r_idx      <= 5'd0;
      r_sof_pend <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_idx      <= ((r_state == FLUSH) && !w_last) ? (r_idx + 5'd1) : 5'd0;
      r_sof_pend <= w_last ? 1'b0 : (r_sof_pend || w_late_sof);
      if (w_late_sof) r_overrun <= 1'b1;
    end
  end

  // Select the stats of the class being flushed.
  always_comb begin
    w_sel_min_x = {COORD_W{1'b1}};
    w_sel_max_x = {COORD_W{1'b0}};
    w_sel_min_y = {COORD_W{1'b1}};
    w_sel_max_y = {COORD_W{1'b0}};
    w_sel_cnt   = {CNT_W{1'b0}};
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (r_idx == 5'(c)) begin
        w_sel_min_x = w_min_x[c];
        w_sel_max_x = w_max_x[c];
        w_sel_min_y = w_min_y[c];
        w_sel_max_y = w_max_y[c];
        w_sel_cnt   = w_cnt[c];
      end
    end
  end

  // Centre is formed from a one-bit-wider sum so it cannot wrap.
  assign w_cx = COORD_W'(({1'b0, w_sel_min_x} + {1'b0, w_sel_max_x}) >> 1);
  assign w_cy = COORD_W'(({1'b0, w_sel_min_y} + {1'b0, w_sel_max_y}) >> 1);

`ifdef COORD_TRACK_MIN_COUNT_EN
  assign w_valid = (w_sel_cnt >= CNT_W'(MIN_PIXELS));
`else
  localparam int unused_min_pixels = MIN_PIXELS;
  assign w_valid = (w_sel_cnt != {CNT_W{1'b0}});
`endif

  assign w_word = pack_coord(w_valid, w_sel_cnt, w_cy, w_cx);

  // Registered RAM write port and end-of-flush pulse.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 5'd0;
      r_wr_data    <= 32'h0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= (r_state == FLUSH);
      r_wr_addr    <= (r_state == FLUSH) ? r_idx : 5'd0;
      r_wr_data    <= (r_state == FLUSH) ? w_word : 32'h0;
      r_frame_done <= r_wr_en && (r_wr_addr == 5'(NUM_CLASSES - 1));
    end
  end

  assign coords_ram_write_en   = r_wr_en;
  assign coords_ram_write_addr = r_wr_addr;
  assign coords_ram_write_data = r_wr_data;
  assign frame_done            = r_frame_done;
  assign overrun               = r_overrun;

endmodule

// File: tb/tb_coord_tracker.sv
// Directed self-checking bench for coord_tracker (NUM_CLASSES=8, MIN_PIXELS=4).
module tb_coord_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        sof, eof, pix_valid;
  logic [4:0]  pix_class;
  logic [9:0]  pix_x, pix_y;
  logic [4:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        frame_done, overrun;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_w [8];

  coord_tracker #(.NUM_CLASSES(8), .CLASS_W(5), .COORD_W(10), .MIN_PIXELS(4)) dut (
    .clk_clk               (clk),
    .reset_reset           (rst),
    .sof                   (sof),
    .eof                   (eof),
    .pix_valid             (pix_valid),
    .pix_class             (pix_class),
    .pix_x                 (pix_x),
    .pix_y                 (pix_y),
    .coords_ram_write_addr (wr_addr),
    .coords_ram_write_en   (wr_en),
    .coords_ram_write_data (wr_data),
    .frame_done            (frame_done),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [4:0] c, input logic [9:0] x, input logic [9:0] y);
    pix_valid = 1'b1; pix_class = c; pix_x = x; pix_y = y;
    tick();
    pix_valid = 1'b0; pix_class = 5'd0; pix_x = 10'd0; pix_y = 10'd0;
  endtask

  task automatic start_frame();
    sof = 1'b1; tick(); sof = 1'b0;
  endtask

  task automatic end_frame();
    eof = 1'b1; tick(); eof = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 8; i++) exp_w[i] = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sof = 1'b0; eof = 1'b0; pix_valid = 1'b0;
    pix_class = 5'd0; pix_x = 10'd0; pix_y = 10'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'h0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL reset: got en=%0b addr=%0d data=%h done=%0b ovr=%0b, need all 0",
               wr_en, wr_addr, wr_data, frame_done, overrun);
      n_err++;
    end
  endtask

  task automatic test_single_pixel();
    clear_exp();
    exp_w[2] = {1'b1, 11'd1, 10'd50, 10'd100};
    start_frame();
    pix(5'd2, 10'd100, 10'd50);
    end_frame();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_w[i]) begin
        $display("FAIL single_w%0d: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                 i, wr_en, wr_addr, wr_data, i, exp_w[i]);
        n_err++;
      end
    end
    tick();
    n_vec++;
    if (frame_done !== 1'b1 || wr_en !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL single_done: got done=%0b en=%0b ovr=%0b, need done=1 en=0 ovr=0",
               frame_done, wr_en, overrun);
      n_err++;
    end
    tick();
    n_vec++;
    if (frame_done !== 1'b0) begin
      $display("FAIL single_done_pulse: got done=%0b, need 0", frame_done);
      n_err++;
    end
  endtask

  task automatic test_corners();
    clear_exp();
    exp_w[0] = {1'b1, 11'd4, 10'd35, 10'd15};
    exp_w[3] = {1'b1, 11'd2, 10'd453, 10'd6};
    exp_w[7] = {1'b1, 11'd1, 10'd1023, 10'd1023};
    start_frame();
    pix(5'd0, 10'd10, 10'd30);
    pix(5'd0, 10'd20, 10'd30);
    pix(5'd0, 10'd10, 10'd40);
    pix(5'd0, 10'd20, 10'd40);
    pix(5'd7, 10'd1023, 10'd1023);
    pix(5'd3, 10'd5, 10'd7);
    eof = 1'b1;
    pix(5'd3, 10'd8, 10'd900);
    eof = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_w[i]) begin
        $display("FAIL corners_w%0d: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                 i, wr_en, wr_addr, wr_data, i, exp_w[i]);
        n_err++;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_drop_and_saturate();
    clear_exp();
    start_frame();
    pix(5'd9, 10'd3, 10'd3);
    pix(5'd8, 10'd4, 10'd4);
    end_frame();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'h0) begin
        $display("FAIL drop_w%0d: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=0",
                 i, wr_en, wr_addr, wr_data, i);
        n_err++;
      end
    end
    repeat (2) tick();
    exp_w[1] = {1'b1, 11'd2047, 10'd300, 10'd200};
    start_frame();
    pix_valid = 1'b1; pix_class = 5'd1; pix_x = 10'd200; pix_y = 10'd300;
    repeat (3000) tick();
    pix_valid = 1'b0; pix_class = 5'd0; pix_x = 10'd0; pix_y = 10'd0;
    end_frame();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_w[i]) begin
        $display("FAIL sat_w%0d: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                 i, wr_en, wr_addr, wr_data, i, exp_w[i]);
        n_err++;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_restart();
    clear_exp();
    exp_w[4] = {1'b1, 11'd1, 10'd11, 10'd9};
    start_frame();
    pix(5'd4, 10'd1, 10'd1);
    start_frame();
    pix(5'd4, 10'd9, 10'd11);
    end_frame();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_w[i]) begin
        $display("FAIL restart_w%0d: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                 i, wr_en, wr_addr, wr_data, i, exp_w[i]);
        n_err++;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_overrun();
    clear_exp();
    exp_w[6] = {1'b1, 11'd1, 10'd60, 10'd40};
    start_frame();
    pix(5'd6, 10'd40, 10'd60);
    end_frame();
    for (int i = 0; i < 8; i++) begin
      sof = (i == 3);
      tick();
      sof = 1'b0;
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_w[i]) begin
        $display("FAIL ovr_w%0d: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                 i, wr_en, wr_addr, wr_data, i, exp_w[i]);
        n_err++;
      end
    end
    tick();
    n_vec++;
    if (frame_done !== 1'b1 || overrun !== 1'b1) begin
      $display("FAIL ovr_flag: got done=%0b ovr=%0b, need done=1 ovr=1", frame_done, overrun);
      n_err++;
    end
    exp_w[6] = {1'b1, 11'd1, 10'd4, 10'd2};
    pix(5'd6, 10'd2, 10'd4);
    end_frame();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_w[i]) begin
        $display("FAIL ovr_next_w%0d: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                 i, wr_en, wr_addr, wr_data, i, exp_w[i]);
        n_err++;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_min_count();
    logic v3;
`ifdef COORD_TRACK_MIN_COUNT_EN
    v3 = 1'b0;
`else
    v3 = 1'b1;
`endif
    clear_exp();
    exp_w[5] = {v3, 11'd3, 10'd10, 10'd12};
    start_frame();
    pix(5'd5, 10'd10, 10'd10);
    pix(5'd5, 10'd12, 10'd10);
    pix(5'd5, 10'd14, 10'd10);
    end_frame();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_w[i]) begin
        $display("FAIL min3_w%0d: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                 i, wr_en, wr_addr, wr_data, i, exp_w[i]);
        n_err++;
      end
    end
    repeat (2) tick();
    exp_w[5] = {1'b1, 11'd4, 10'd10, 10'd13};
    start_frame();
    pix(5'd5, 10'd10, 10'd10);
    pix(5'd5, 10'd12, 10'd10);
    pix(5'd5, 10'd14, 10'd10);
    pix(5'd5, 10'd16, 10'd10);
    end_frame();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_w[i]) begin
        $display("FAIL min4_w%0d: got en=%0b addr=%0d data=%h, need en=1 addr=%0d data=%h",
                 i, wr_en, wr_addr, wr_data, i, exp_w[i]);
        n_err++;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_flush();
    int bad;
    start_frame();
    pix(5'd1, 10'd7, 10'd7);
    end_frame();
    repeat (3) tick();
    sof = 1'b1; tick(); sof = 1'b0;
    n_vec++;
    if (overrun !== 1'b1 || wr_en !== 1'b1) begin
      $display("FAIL rstflush_pre: got ovr=%0b en=%0b, need ovr=1 en=1", overrun, wr_en);
      n_err++;
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (wr_en !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL rstflush_cut: got en=%0b done=%0b ovr=%0b, need 0 0 0", wr_en, frame_done, overrun);
      n_err++;
    end
    repeat (2) tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) eof = 1'b1;
      tick();
      eof = 1'b0;
      if (wr_en !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      $display("FAIL rstflush_quiet: got %0d cycles with activity, need 0", bad);
      n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_corners();
    test_drop_and_saturate();
    test_restart();
    test_overrun();
    test_min_count();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coord_tracker.md
Name: coord_tracker

Overview:
Per-frame colour-blob locator between the D8M pixel classifier and the coords RAM that the Nios II system reads. It consumes a classified pixel stream and tracks a bounding box and pixel count per colour class. At end of frame it writes one packed 32-bit coordinate word per class into the coords RAM write port, at address = class index.

Parameters:
NUM_CLASSES, 8, number of tracked classes (1..32); also the flush length.
CLASS_W, 5, width of pixel_class.
COORD_W, 10, width of the x/y coordinates.
MIN_PIXELS, 16, validity threshold; used only when COORD_TRACK_MIN_COUNT_EN is defined.

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
sof  in  1  start-of-frame pulse
eof  in  1  end-of-frame pulse
pix_valid  in  1  pixel qualifier
pix_class  in  CLASS_W  class of the current pixel
pix_x  in  COORD_W  pixel column
pix_y  in  COORD_W  pixel row
coords_ram_write_addr  out  5  coords RAM write address
coords_ram_write_en  out  1  coords RAM write strobe
coords_ram_write_data  out  32  packed coordinate word
frame_done  out  1  one-cycle pulse after the last flush write
overrun  out  1  sticky flag; cleared only by reset

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is synchronous, active-high, on reset_reset.
- Reset: state=IDLE; all stats cleared (min=all-ones, max=0, count=0); all outputs 0.
- States and transitions:
  - IDLE: sof -> ACCUM. Pixels and eof are ignored.
  - ACCUM: on each pix_valid with pix_class < NUM_CLASSES, update that class (min/max x, min/max y, count+1).
  - ACCUM boundary cases:
    - pix_class >= NUM_CLASSES: pixel dropped.
    - count saturates at 2047.
    - eof -> FLUSH. A pixel in the eof cycle is still accumulated.
    - sof in ACCUM: clear stats and restart, with no flush.
  - FLUSH: index i = 0..NUM_CLASSES-1, one word per cycle.
    - Write i occurs at cycle eof+1+i, with write_en=1 and write_addr=i.
    - After the last write, go to IDLE; frame_done=1 for one cycle, on the cycle after the last write.
    - Stats are cleared on exit.
- Word format:
  - [31] valid = count>=1.
  - [30:20] count.
  - [19:10] cy = (min_y+max_y)>>1.
  - [9:0] cx = (min_x+max_x)>>1.
  - The sum is computed at COORD_W+1 bits, so it never overflows.
  - An empty class writes 32'h0.
- sof during FLUSH: the flush completes unchanged, overrun is set, and the pending sof is latched. The FSM then enters ACCUM directly instead of IDLE. Pixels arriving during FLUSH are dropped.
- eof in IDLE or FLUSH: ignored.
- Simultaneous sof and eof in ACCUM: eof has priority (flush), and sof is treated as arriving during FLUSH.
- Reset mid-FLUSH: write_en=0 on the next cycle, and no frame_done.
- Outputs are registered, and write_en is 0 outside FLUSH.

Optional Feature:
COORD_TRACK_MIN_COUNT_EN
- Defined: valid bit = count >= MIN_PIXELS. cx, cy and count are still written when the word is invalid.
- Undefined: valid = count >= 1, and MIN_PIXELS is unused.

Decomposition:
- Package coord_track_pkg holds:
  - the state enum (IDLE, ACCUM, FLUSH);
  - field position/width localparams (VALID_BIT, CNT_W=11, CNT_LSB=20, CY_LSB=10, CX_LSB=0);
  - the pack_coord() function.
- Sub-module coord_class_stats: a per-class min/max/count accumulator with a clear input. It is instantiated NUM_CLASSES times via generate, and the top muxes its outputs by flush index.

Test Plan:
1. Reset held for 3 cycles mid-FLUSH -> write_en=0 from the next cycle, no frame_done, overrun=0.
2. sof; one pixel class 2 at (100,50); eof -> 8 writes at cycles eof+1..eof+8.
   - addr 2 data = {1, 11'd1, 10'd50, 10'd100}.
   - All other addresses 32'h0.
   - frame_done at eof+9.
3. Class 0 pixels at corners (10,30),(20,30),(10,40),(20,40) -> addr 0 = {1, 11'd4, 10'd35, 10'd15}.
4. Pixel with class 9 at NUM_CLASSES=8 -> dropped; all words 0. 3000 pixels of class 1 -> count field 2047.
5. sof asserted at flush cycle 3 -> all 8 writes still occur; overrun=1; FSM enters ACCUM; a subsequent frame is accumulated correctly.
6. With COORD_TRACK_MIN_COUNT_EN and MIN_PIXELS=4: 3 class-5 pixels -> bit31=0, count=3. 4 pixels -> bit31=1.
